// File: rtl/run_detect_multi_pkg.sv
// Shared types and default parameters for the multi-channel run-length detector.
package run_detect_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HIT   = 2'd2
    } run_state_t;

    localparam int CHANNELS_DEF    = 4;
    localparam int MAX_RUN_DEF     = 15;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/run_detect_multi_if.sv
// Control/observation bundle for run_detect_multi. The design drives the
// detect flags and run counts; everything else comes from the surrounding logic.
interface run_detect_multi_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 4
);
    logic                      tick;
    logic                      mode;
    logic [CNT_W-1:0]          run_len;
    logic [CHANNELS-1:0]       w;
    logic [CHANNELS-1:0]       out;
    logic                      any_out;
    logic [CHANNELS*CNT_W-1:0] run_count;

    modport master (
        output tick, mode, run_len, w,
        input  out, any_out, run_count
    );

    modport slave (
        input  tick, mode, run_len, w,
        output out, any_out, run_count
    );
endinterface

// File: rtl/run_detect_multi_channel.sv
// One detector channel: input synchroniser, run FSM, saturating run counter
// and the registered detect flag.
//
//   state | meaning
//   IDLE  | input low at last tick, no run in progress
//   COUNT | run in progress, threshold not yet reached
//   HIT   | run has reached threshold; held until input drops
module run_channel
    import run_detect_pkg::*;
#(
    parameter int MAX_RUN     = 15,
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick_i,
    input  logic             mode_i,
    input  logic [CNT_W-1:0] thr_i,
    input  logic             w_i,
    output logic             out_o,
    output logic             out_d_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] MAX_RUN_C = CNT_W'(MAX_RUN);

    logic ws;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign ws = w_i;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;

        // Synchroniser shift chain, runs every clk regardless of tick.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) sync_q <= '0;
            else          sync_q <= (sync_q << 1) | SYNC_STAGES'(w_i);
        end

        assign ws = sync_q[SYNC_STAGES-1];
    end

    run_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             out_q, out_d;

    // Next-state, counter and detect-flag decode.
    always_comb begin
        cnt_inc = (cnt_q >= MAX_RUN_C) ? MAX_RUN_C : cnt_q + CNT_W'(1);
        state_d = state_q;
        cnt_d   = cnt_q;
        if (tick_i) begin
            if (!ws) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_inc;
                case (state_q)
                    IDLE, COUNT: state_d = (cnt_inc >= thr_i) ? HIT : COUNT;
                    HIT:         state_d = HIT;
                    default:     state_d = IDLE;
                endcase
            end
        end
        // Level mode follows HIT; pulse mode only flags the entry into HIT.
        out_d = (state_d == HIT) && (!mode_i || (state_q != HIT));
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign out_o   = out_q;
    assign out_d_o = out_d;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/run_detect_multi.sv
// Multi-channel run-length detector top: threshold clamp, channel array and
// the registered OR of all detect flags.
module run_detect_multi
    import run_detect_pkg::*;
#(
    parameter int  CHANNELS    = CHANNELS_DEF,
    parameter int  MAX_RUN     = MAX_RUN_DEF,
    parameter int  SYNC_STAGES = SYNC_STAGES_DEF,
    localparam int CNT_W       = $clog2(MAX_RUN + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    run_detect_multi_if.slave  bus
);

    logic [CNT_W-1:0]          thr;
    logic [CHANNELS-1:0]       out_q_w;
    logic [CHANNELS-1:0]       out_d_w;
    logic [CHANNELS*CNT_W-1:0] cnt_w;
    logic                      any_out_q;

    // Effective threshold: zero means "hit on first high tick", clamp at MAX_RUN.
    always_comb begin
        if (bus.run_len == '0)
            thr = CNT_W'(1);
        else if ({1'b0, bus.run_len} > (CNT_W+1)'(MAX_RUN))
            thr = CNT_W'(MAX_RUN);
        else
            thr = bus.run_len;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        run_channel #(
            .MAX_RUN     (MAX_RUN),
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .tick_i  (bus.tick),
            .mode_i  (bus.mode),
            .thr_i   (thr),
            .w_i     (bus.w[i]),
            .out_o   (out_q_w[i]),
            .out_d_o (out_d_w[i]),
            .cnt_o   (cnt_w[i*CNT_W +: CNT_W])
        );
    end

    // any_out uses the channels' next-state flags so it lines up with out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) any_out_q <= 1'b0;
        else          any_out_q <= |out_d_w;
    end

    assign bus.out       = out_q_w;
    assign bus.any_out   = any_out_q;
    assign bus.run_count = cnt_w;

endmodule
